// File: rtl/sobel_pkg.sv
// Shared widths, Sobel kernel weights and arithmetic helpers for the edge pipeline.
package sobel_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned MAG_W   = 11;
  localparam int unsigned GRAD_W  = 11;
  localparam int unsigned SUM_W   = 10;
  localparam int unsigned COORD_W = 11;

  localparam int unsigned K_EDGE = 1;
  localparam int unsigned K_MID  = 2;

  // Weighted 1-2-1 column/row sum; max 4*255 = 1020 fits SUM_W.
  function automatic logic [SUM_W-1:0] sum121(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
    return SUM_W'(K_EDGE) * SUM_W'(a) + SUM_W'(K_MID) * SUM_W'(b) + SUM_W'(K_EDGE) * SUM_W'(c);
  endfunction

  function automatic logic [SUM_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? SUM_W'(-g) : SUM_W'(g);
  endfunction

  function automatic logic [PIX_W-1:0] sat8(input logic [MAG_W-1:0] mag);
    return (mag > MAG_W'(255)) ? '1 : mag[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Sobel S1-S2: registered 1-2-1 sums, then registered |gx| and |gy|.
module sobel_kernel
  import sobel_pkg::*;
(
  input  logic              CAMERA_CLK,
  input  logic              rst,
  input  logic              win_valid,
  input  logic [PIX_W-1:0]  ul,
  input  logic [PIX_W-1:0]  uc,
  input  logic [PIX_W-1:0]  ur,
  input  logic [PIX_W-1:0]  ml,
  input  logic [PIX_W-1:0]  mr,
  input  logic [PIX_W-1:0]  dl,
  input  logic [PIX_W-1:0]  dc,
  input  logic [PIX_W-1:0]  dr,
  output logic              s2_valid,
  output logic [SUM_W-1:0]  abs_gx,
  output logic [SUM_W-1:0]  abs_gy
);

  logic                     s1_valid;
  logic [SUM_W-1:0]         px, nx, py, ny;
  logic signed [GRAD_W-1:0] gx, gy;

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      s1_valid <= 1'b0;
      px       <= '0;
      nx       <= '0;
      py       <= '0;
      ny       <= '0;
    end else begin
      s1_valid <= win_valid;
      px       <= sum121(ur, mr, dr);
      nx       <= sum121(ul, ml, dl);
      py       <= sum121(dl, dc, dr);
      ny       <= sum121(ul, uc, ur);
    end
  end

  always_comb begin
    gx = $signed({1'b0, px}) - $signed({1'b0, nx});
    gy = $signed({1'b0, py}) - $signed({1'b0, ny});
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      s2_valid <= 1'b0;
      abs_gx   <= '0;
      abs_gy   <= '0;
    end else begin
      s2_valid <= s1_valid;
      abs_gx   <= abs_grad(gx);
      abs_gy   <= abs_grad(gy);
    end
  end

endmodule

// File: rtl/sobel_edge_pipe.sv
// Sobel edge pipeline top: kernel S1-S2, S3 magnitude/threshold/border, per-frame edge count.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH          = 768,
  parameter int unsigned HEIGHT         = 512,
  parameter int unsigned DEFAULT_THRESH = 100,
  parameter int unsigned CNT_BITS       = 19
) (
  input  logic                CAMERA_CLK,
  input  logic                rst,
  input  logic                win_valid,
  input  logic [PIX_W-1:0]    ul,
  input  logic [PIX_W-1:0]    uc,
  input  logic [PIX_W-1:0]    ur,
  input  logic [PIX_W-1:0]    ml,
  input  logic [PIX_W-1:0]    mc,
  input  logic [PIX_W-1:0]    mr,
  input  logic [PIX_W-1:0]    dl,
  input  logic [PIX_W-1:0]    dc,
  input  logic [PIX_W-1:0]    dr,
  input  logic [COORD_W-1:0]  win_x,
  input  logic [COORD_W-1:0]  win_y,
  input  logic [PIX_W-1:0]    thresh_in,
  input  logic                thresh_load,
  output logic                out_valid,
  output logic [PIX_W-1:0]    edge_mag,
  output logic                edge_bit,
  output logic [COORD_W-1:0]  out_x,
  output logic [COORD_W-1:0]  out_y,
  output logic                frame_done,
  output logic [CNT_BITS-1:0] edge_count
);

  logic                s2_valid;
  logic [SUM_W-1:0]    abs_gx, abs_gy;
  logic [COORD_W-1:0]  x1, y1, x2, y2;
  logic [MAG_W-1:0]    mag;
  logic                border, last_pix;
  logic [PIX_W-1:0]    mag8, thr_eff;
  logic                bit_next;
  logic [PIX_W-1:0]    shadow_thresh, active_thresh;
  logic [CNT_BITS-1:0] run_count, run_next;

  sobel_kernel u_kernel (
    .CAMERA_CLK (CAMERA_CLK),
    .rst        (rst),
    .win_valid  (win_valid),
    .ul         (ul),
    .uc         (uc),
    .ur         (ur),
    .ml         (ml),
    .mr         (mr),
    .dl         (dl),
    .dc         (dc),
    .dr         (dr),
    .s2_valid   (s2_valid),
    .abs_gx     (abs_gx),
    .abs_gy     (abs_gy)
  );

  // The centre pixel does not enter the Sobel kernel.
  logic unused_mc;
  assign unused_mc = ^mc;

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      x1 <= '0;
      y1 <= '0;
      x2 <= '0;
      y2 <= '0;
    end else begin
      x1 <= win_x;
      y1 <= win_y;
      x2 <= x1;
      y2 <= y1;
    end
  end

  // While frame_done is high the active register is being reloaded, so the pixel
  // now entering S3 (first of the next frame) must already see the shadow value.
  always_comb begin
    mag      = MAG_W'(abs_gx) + MAG_W'(abs_gy);
    border   = (x2 == '0) || (x2 == COORD_W'(HEIGHT - 1)) ||
               (y2 == '0) || (y2 == COORD_W'(WIDTH - 1));
    last_pix = (x2 == COORD_W'(HEIGHT - 1)) && (y2 == COORD_W'(WIDTH - 1));
    mag8     = border ? '0 : sat8(mag);
    thr_eff  = frame_done ? shadow_thresh : active_thresh;
    bit_next = (mag8 >= thr_eff);
    run_next = run_count;
    if (out_valid && edge_bit && (run_count != '1))
      run_next = run_count + CNT_BITS'(1);
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      out_valid     <= 1'b0;
      edge_mag      <= '0;
      edge_bit      <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      frame_done    <= 1'b0;
      edge_count    <= '0;
      run_count     <= '0;
      shadow_thresh <= PIX_W'(DEFAULT_THRESH);
      active_thresh <= PIX_W'(DEFAULT_THRESH);
    end else begin
      out_valid  <= s2_valid;
      frame_done <= s2_valid && last_pix;
      if (s2_valid) begin
        edge_mag <= mag8;
        edge_bit <= bit_next;
        out_x    <= x2;
        out_y    <= y2;
      end
      if (thresh_load)
        shadow_thresh <= thresh_in;
      if (frame_done) begin
        active_thresh <= shadow_thresh;
        edge_count    <= run_next;
        run_count     <= '0;
      end else begin
        run_count <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed bench for sobel_edge_pipe on a reduced 16x12 frame with an 8-bit counter.
module tb_sobel_edge_pipe;

  localparam int unsigned TW = 16;
  localparam int unsigned TH = 12;

  localparam logic [71:0] FLAT  = {9{8'd50}};
  localparam logic [71:0] STEP  = {8'd0, 8'd100, 8'd200, 8'd0, 8'd100, 8'd200, 8'd0, 8'd100, 8'd200};
  localparam logic [71:0] SMALL = {8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20};
  localparam logic [71:0] DIAG  = {8'd0, 8'd0, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] NEG   = {8'd30, 8'd0, 8'd0, 8'd30, 8'd0, 8'd0, 8'd30, 8'd0, 8'd0};
  localparam logic [71:0] T100  = {8'd0, 8'd0, 8'd25, 8'd0, 8'd0, 8'd25, 8'd0, 8'd0, 8'd25};
  localparam logic [71:0] T98   = {8'd0, 8'd0, 8'd25, 8'd0, 8'd0, 8'd24, 8'd0, 8'd0, 8'd25};

  logic        CAMERA_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        win_valid = 1'b0;
  logic [7:0]  ul = '0, uc = '0, ur = '0, ml = '0, mc = '0, mr = '0, dl = '0, dc = '0, dr = '0;
  logic [10:0] win_x = '0, win_y = '0;
  logic [7:0]  thresh_in = '0;
  logic        thresh_load = 1'b0;
  logic        out_valid, edge_bit, frame_done;
  logic [7:0]  edge_mag;
  logic [10:0] out_x, out_y;
  logic [7:0]  edge_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned fd_cnt = 0;
  bit          stream_chk = 1'b0;
  logic [2:0]  hv = '0;
  logic [10:0] hx [3];
  logic [10:0] hy [3];

  always #5 CAMERA_CLK = ~CAMERA_CLK;

  sobel_edge_pipe #(
    .WIDTH          (TW),
    .HEIGHT         (TH),
    .DEFAULT_THRESH (100),
    .CNT_BITS       (8)
  ) dut (
    .CAMERA_CLK  (CAMERA_CLK),
    .rst         (rst),
    .win_valid   (win_valid),
    .ul (ul), .uc (uc), .ur (ur),
    .ml (ml), .mc (mc), .mr (mr),
    .dl (dl), .dc (dc), .dr (dr),
    .win_x       (win_x),
    .win_y       (win_y),
    .thresh_in   (thresh_in),
    .thresh_load (thresh_load),
    .out_valid   (out_valid),
    .edge_mag    (edge_mag),
    .edge_bit    (edge_bit),
    .out_x       (out_x),
    .out_y       (out_y),
    .frame_done  (frame_done),
    .edge_count  (edge_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive a window, step past the edge, then track what should emerge.
  task automatic put(input logic [71:0] w, input int unsigned x, input int unsigned y, input logic v);
    {ul, uc, ur, ml, mc, mr, dl, dc, dr} = w;
    win_x     = 11'(x);
    win_y     = 11'(y);
    win_valid = v;
    @(posedge CAMERA_CLK);
    #1;
    thresh_load = 1'b0;
    hv    = {hv[1:0], v};
    hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = 11'(x);
    hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = 11'(y);
    if (frame_done) fd_cnt++;
    if (stream_chk) begin
      chk("stream_valid", 32'(out_valid), 32'(hv[2]));
      if (hv[2]) begin
        chk("stream_x", 32'(out_x), 32'(hx[2]));
        chk("stream_y", 32'(out_y), 32'(hy[2]));
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) put(FLAT, 0, 0, 1'b0);
  endtask

  task automatic check_pix(input string tag, input int unsigned mag, input logic b);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mag"}, 32'(edge_mag), 32'(mag));
    chk({tag, "_bit"}, 32'(edge_bit), 32'(b));
  endtask

  initial begin
    int unsigned nstep;
    hx = '{default: '0};
    hy = '{default: '0};

    idle(2);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_mag", 32'(edge_mag), 0);
    chk("rst_bit", 32'(edge_bit), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_cnt", 32'(edge_count), 0);
    rst = 1'b0;
    idle(1);

    put(FLAT, 10, 10, 1'b1);
    idle(1);
    chk("lat_early", 32'(out_valid), 0);
    idle(1);
    check_pix("flat", 0, 1'b0);
    chk("flat_x", 32'(out_x), 10);
    chk("flat_y", 32'(out_y), 10);

    put(STEP, 3, 4, 1'b1); idle(2);
    check_pix("step", 255, 1'b1);
    idle(1);
    chk("hold_valid", 32'(out_valid), 0);
    chk("hold_mag", 32'(edge_mag), 255);
    chk("hold_x", 32'(out_x), 3);

    put(SMALL, 5, 6, 1'b1); idle(2); check_pix("small", 80, 1'b0);
    put(DIAG, 2, 2, 1'b1);  idle(2); check_pix("diag", 60, 1'b0);
    put(NEG, 7, 9, 1'b1);   idle(2); check_pix("neg", 120, 1'b1);
    put(STEP, 0, 5, 1'b1);  idle(2); check_pix("border_top", 0, 1'b0);
    chk("border_top_fd", 32'(frame_done), 0);
    put(STEP, 4, 0, 1'b1);  idle(2); check_pix("border_left", 0, 1'b0);
    put(STEP, TH - 1, TW - 1, 1'b1); idle(2);
    check_pix("border_last", 0, 1'b0);
    chk("last_fd", 32'(frame_done), 1);
    idle(1);
    chk("fd_pulse", 32'(frame_done), 0);
    chk("cnt_frame1", 32'(edge_count), 2);

    thresh_in = 8'd60; thresh_load = 1'b1;
    put(SMALL, 5, 6, 1'b1); idle(2); check_pix("small_shadow", 80, 1'b0);
    put(FLAT, TH - 1, TW - 1, 1'b1); idle(2);
    chk("fd2", 32'(frame_done), 1);
    thresh_in = 8'd90; thresh_load = 1'b1;
    put(SMALL, 5, 6, 1'b1);
    chk("cnt_frame2", 32'(edge_count), 0);
    idle(2); check_pix("small_t60", 80, 1'b1);
    put(FLAT, TH - 1, TW - 1, 1'b1); idle(3);
    chk("cnt_frame3", 32'(edge_count), 1);
    put(SMALL, 5, 6, 1'b1); idle(2); check_pix("small_t90", 80, 1'b0);

    idle(3);
    fd_cnt = 0;
    stream_chk = 1'b1;
    for (int unsigned f = 0; f < 2; f++) begin
      nstep = 0;
      for (int unsigned r = 0; r < TH; r++) begin
        for (int unsigned c = 0; c < TW; c++) begin
          if ($urandom_range(3) == 0) idle(1);
          if (r > 0 && r < TH - 1 && c > 0 && c < TW - 1 && nstep < ((f == 0) ? 50 : 7)) begin
            put(STEP, r, c, 1'b1);
            nstep++;
          end else begin
            put(FLAT, r, c, 1'b1);
          end
        end
      end
      idle(3);
      chk("stream_fd", fd_cnt, f + 1);
      chk("stream_cnt", 32'(edge_count), (f == 0) ? 50 : 7);
    end
    stream_chk = 1'b0;

    for (int unsigned i = 0; i < 300; i++) put(STEP, 5, 5, 1'b1);
    put(FLAT, TH - 1, TW - 1, 1'b1); idle(3);
    chk("cnt_saturate", 32'(edge_count), 255);

    put(STEP, 5, 5, 1'b1);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("midrst_valid", 32'(out_valid), 0);
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) chk("midrst_novalid", 32'(out_valid), 0);
    idle(1);
    chk("midrst_valid2", 32'(out_valid), 0);
    idle(1);
    chk("midrst_valid3", 32'(out_valid), 0);
    chk("midrst_fd", 32'(frame_done), 0);
    chk("midrst_cnt", 32'(edge_count), 0);
    chk("midrst_mag", 32'(edge_mag), 0);
    put(T98, 5, 5, 1'b1);  idle(2); check_pix("thr_below", 98, 1'b0);
    put(T100, 5, 5, 1'b1); idle(2); check_pix("thr_equal", 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_edge_pipe.md
Name: sobel_edge_pipe

Overview:
- Consumes the 3x3 grayscale window (ul..dr) produced by the frame buffer in read mode.
- Computes the Sobel gradient magnitude, thresholds it and emits one edge pixel per input window.
- Counts edge pixels per frame for the downstream detection logic.
- Pipelined at CAMERA_CLK rate with no backpressure; sits between the frame buffer and the object-detection stage.

Parameters:
- WIDTH, 768, image width in pixels (columns; win_y range 0..WIDTH-1).
- HEIGHT, 512, image height in pixels (rows; win_x range 0..HEIGHT-1).
- DEFAULT_THRESH, 100, active and shadow threshold value after reset.
- CNT_BITS, 19, edge counter width; must satisfy 2^CNT_BITS > WIDTH*HEIGHT.

Ports:
- CAMERA_CLK  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- win_valid  in  1  window inputs valid this cycle.
- ul,uc,ur,ml,mc,mr,dl,dc,dr  in  8 each  3x3 grayscale window; mc is the centre pixel.
- win_x  in  11  row of the centre pixel.
- win_y  in  11  column of the centre pixel.
- thresh_in  in  8  new threshold value.
- thresh_load  in  1  1-cycle strobe; captures thresh_in into the shadow register.
- out_valid  out  1  output pixel valid.
- edge_mag  out  8  saturated gradient magnitude.
- edge_bit  out  1  1 when edge_mag >= active threshold.
- out_x, out_y  out  11 each  coordinates carried with the pixel.
- frame_done  out  1  1-cycle pulse on the last pixel of a frame.
- edge_count  out  CNT_BITS  edge_bit total of the last completed frame.

Behaviour:
- Reset:
  - All outputs 0; pipeline valids 0; running counter 0.
  - Active and shadow thresholds = DEFAULT_THRESH.
  - rst mid-frame discards in-flight pixels, with no frame_done and no edge_count update.
- Pipeline, 3 stages; latency is exactly 3 cycles from win_valid to out_valid.
  - Stage validity is a shift of win_valid. Bubbles propagate and never stall.
  - x/y are delayed in lockstep with the data.
- S1 registers four unsigned 10-bit sums:
  - px = ur+2mr+dr, nx = ul+2ml+dl.
  - py = dl+2dc+dr, ny = ul+2uc+ur.
  - Each sum has max 1020.
- S2 forms signed 11-bit gx = px-nx and gy = py-ny, then registers |gx| and |gy| (10 bits each).
- S3:
  - mag = |gx|+|gy| in 11 bits (max 2040); edge_mag = 255 if mag > 255, else mag[7:0].
  - edge_bit = (edge_mag >= active_thresh).
- Border rule:
  - Applies when the centre is on row 0, row HEIGHT-1, column 0 or column WIDTH-1.
  - Then edge_mag = 0 and edge_bit = 0, regardless of window data.
- Invalid cycles:
  - When out_valid = 0, edge_mag, edge_bit, out_x and out_y hold their last values.
- Counting:
  - The running counter increments on out_valid & edge_bit.
  - Last pixel = out_valid with out_x == HEIGHT-1 and out_y == WIDTH-1.
  - On the last pixel, frame_done = 1 in the same cycle as out_valid.
  - In that cycle, edge_count <= running count + edge_bit (always +0 here, because the pixel is a border pixel).
  - The running counter clears to 0 in the same cycle.
- Counter saturation: the running counter saturates at all-ones and never wraps.
- Threshold loading:
  - thresh_load writes the shadow register immediately.
  - The active threshold is loaded from shadow on the frame_done cycle, so it takes effect from the next frame's first output.
  - thresh_load coincident with frame_done: the new value goes to shadow only; active receives the old shadow.
- Out-of-order coordinates are not checked; pixels are processed as given.

Decomposition:
- Shared package (sobel_pkg):
  - MAG_W = 11, GRAD_W = 11, PIX_W = 8.
  - Sobel kernel weight constants.
  - Function sat8(mag) for the 255 saturation.
- Sub-module sobel_kernel: purely arithmetic S1–S2 slice (window in, |gx| and |gy| out, with valid).
- The top level holds S3, the border rule, the threshold shadow/active registers and the frame counter.

Test Plan:
- Flat window, all 9 pixels = 50, at (10,10) -> 3 cycles later edge_mag = 0, edge_bit = 0, out_x = 10, out_y = 10.
- Vertical step, left column = 0 and right column = 200 (thresh 100):
  - gx = 800, gy = 0, so mag = 800 saturates.
  - Response: edge_mag = 255, edge_bit = 1.
- Small gradient, ul = ml = dl = 0 and ur = mr = dr = 20: mag = 80, so edge_mag = 80 and edge_bit = 0 at thresh 100.
  - Same window with thresh_load = 60 mid-frame: still edge_bit = 0 until frame_done.
  - Same window in the next frame: edge_bit = 1.
- Border, window as in the vertical-step case at (0,5) and at (511,767) -> edge_mag = 0, edge_bit = 0.
  - The (511,767) output asserts frame_done.
- Full frame of 768x512 windows with the step pattern on exactly 1000 interior pixels:
  - Response: frame_done once; edge_count = 1000; the second frame starts counting from 0.
  - Insert random win_valid gaps: counts unchanged, latency still 3.
- Assert rst two cycles after a step window enters -> out_valid never asserts for it; edge_count = 0; threshold = 100.
